// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the 16-bit PRBS checker.
//   state_t   : checker FSM states
//   TAP_MASK  : taps 15/13/12/10 of the Fibonacci PRBS16 (left shift)
//   LFSR16_W  : history register width
//   lfsr_pred : next PRBS bit predicted from the last 16 bits
package lfsr_pkg;
    localparam int LFSR16_W = 16;
    localparam logic [LFSR16_W-1:0] TAP_MASK = 16'hB400;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED, LOST} state_t;
    function automatic logic lfsr_pred(input logic [LFSR16_W-1:0] h);
        return ^(h & TAP_MASK);
    endfunction
endpackage

// File: rtl/lfsr16_chk_win.sv
// lfsr16_chk_win: loss-of-lock window, counts errors over WINDOW valid bits.
//   clk, rst : clock, synchronous active-high reset
//   tick     : a LOCKED valid bit is consumed this cycle
//   err      : that bit mismatched
//   clear    : hold window counters at zero (checker not LOCKED)
//   loss     : this bit brings the window error count to LOSS_THRESH
module lfsr16_chk_win #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic err,
    input  logic clear,
    output logic loss
);
    localparam int CW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1) + 1;
    logic [CW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic [EW-1:0] sum;
    logic          wrap;
    // The last bit of a window still counts toward that window before the wrap.
    assign sum  = win_err + EW'(err);
    assign wrap = win_cnt == CW'(WINDOW - 1);
    assign loss = tick && (sum >= EW'(LOSS_THRESH));
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (tick) begin
            win_cnt <= wrap ? '0 : win_cnt + CW'(1);
            win_err <= wrap ? '0 : sum;
        end
    end
endmodule

// File: rtl/lfsr16_prbs_checker.sv
// lfsr16_prbs_checker: self-synchronising PRBS16 receive checker with lock,
// error counting and loss-of-lock detection.
//   clk, rst : clock, synchronous active-high reset
//   in_vld   : in_bit valid this cycle
//   in_bit   : received serial PRBS bit
//   clr_cnt  : clear err_cnt; also leaves LOST when auto-relock is off
//   locked   : checker is LOCKED
//   lost     : checker is LOST
//   err      : one-cycle pulse for a mismatch on a LOCKED bit
//   err_cnt  : saturating count of LOCKED mismatches
// Build option: define LFSR_CHK_RELOCK_EN to return from LOST to SEARCH
// automatically on the next cycle instead of waiting for clr_cnt.
module lfsr16_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT    = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             lost,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int RW = $clog2(LOCK_CNT + 1);
    state_t              state, state_n;
    logic [LFSR16_W-1:0] hist, hist_n;
    logic [3:0]          fill, fill_n;
    logic [RW-1:0]       run, run_n;
    logic                pred, mism, lk_tick, loss;
    assign pred    = lfsr_pred(hist);
    assign mism    = pred ^ in_bit;
    assign lk_tick = in_vld && (state == LOCKED);
    assign locked  = state == LOCKED;
    assign lost    = state == LOST;
    lfsr16_chk_win #(.WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)) u_win (
        .clk   (clk),
        .rst   (rst),
        .tick  (lk_tick),
        .err   (mism),
        .clear (state != LOCKED),
        .loss  (loss)
    );
    always_comb begin
        state_n = state;
        hist_n  = hist;
        fill_n  = fill;
        run_n   = run;
        case (state)
            SEARCH: if (in_vld) begin
                hist_n = {hist[LFSR16_W-2:0], in_bit};
                fill_n = fill + 4'd1;
                if (fill == 4'd15) begin
                    state_n = VERIFY;
                    run_n   = '0;
                end
            end
            VERIFY: if (in_vld) begin
                hist_n = {hist[LFSR16_W-2:0], in_bit};
                // An all-zero history is the LFSR lock-up state and predicts zeros forever.
                if (mism || hist == '0) begin
                    state_n = SEARCH;
                    fill_n  = '0;
                    run_n   = '0;
                end else begin
                    run_n = run + RW'(1);
                    if (run_n == RW'(LOCK_CNT)) state_n = LOCKED;
                end
            end
            // Flywheel: feed back the prediction so a flipped bit cannot corrupt later predictions.
            LOCKED: if (in_vld) begin
                hist_n = {hist[LFSR16_W-2:0], pred};
                if (loss) state_n = LOST;
            end
            LOST: begin
`ifdef LFSR_CHK_RELOCK_EN
                state_n = SEARCH;
                fill_n  = '0;
                run_n   = '0;
`else
                if (clr_cnt) begin
                    state_n = SEARCH;
                    fill_n  = '0;
                    run_n   = '0;
                end
`endif
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEARCH;
            hist    <= '0;
            fill    <= '0;
            run     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            hist    <= hist_n;
            fill    <= fill_n;
            run     <= run_n;
            err     <= lk_tick && mism;
            err_cnt <= clr_cnt ? '0 :
                       (lk_tick && mism && err_cnt != '1) ? err_cnt + CNT_W'(1) : err_cnt;
        end
    end
endmodule

// File: tb/tb_lfsr16_prbs_checker.sv
// tb_lfsr16_prbs_checker: directed self-checking bench for lfsr16_prbs_checker.
module tb_lfsr16_prbs_checker;
    logic        clk = 1'b0;
    logic        rst, in_vld, in_bit, clr_cnt;
    logic        locked, lost, err;
    logic [15:0] err_cnt;
    logic [15:0] g;
    int          n_cmp = 0;
    int          n_bad = 0;

    lfsr16_prbs_checker dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_bit  (in_bit),
        .clr_cnt (clr_cnt),
        .locked  (locked),
        .lost    (lost),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic v, input logic b);
        in_vld = v;
        in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip);
        logic b;
        b = g[15] ^ g[13] ^ g[12] ^ g[10];
        g = {g[14:0], b};
        tick(1'b1, b ^ flip);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_vld = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        g = 16'he45b;
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_lost", lost, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", err_cnt, 0);

        // 1: clean lock timing and long clean run
        send_n(47);
        chk("t1_not_yet", locked, 0);
        send(1'b0);
        chk("t1_locked", locked, 1);
        send_n(10000);
        chk("t1_still_locked", locked, 1);
        chk("t1_cnt0", err_cnt, 0);

        // 2: single flipped bit
        send(1'b1);
        chk("t2_err", err, 1);
        chk("t2_cnt1", err_cnt, 1);
        send(1'b0);
        chk("t2_err_drop", err, 0);
        send_n(20);
        chk("t2_cnt_hold", err_cnt, 1);
        chk("t2_flywheel", locked, 1);

        // 5b: in_vld low ignores junk; clr_cnt beats an increment
        tick(1'b0, ~in_bit);
        chk("t5_novld_err", err, 0);
        chk("t5_novld_cnt", err_cnt, 1);
        clr_cnt = 1'b1;
        send(1'b1);
        clr_cnt = 1'b0;
        chk("t5_clr_err", err, 1);
        chk("t5_clr_cnt", err_cnt, 0);

        // 6: reset while locked
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        chk("t6_locked", locked, 0);
        chk("t6_lost", lost, 0);
        chk("t6_err", err, 0);
        chk("t6_cnt", err_cnt, 0);
        send_n(47);
        chk("t6_not_yet", locked, 0);
        send(1'b0);
        chk("t6_relocked", locked, 1);

        // 3: 8 errors in one window force LOST
        for (int i = 0; i < 7; i++) send(1'b1);
        chk("t3_7_lost", lost, 0);
        chk("t3_7_cnt", err_cnt, 7);
        send(1'b1);
        chk("t3_8_lost", lost, 1);
        chk("t3_8_locked", locked, 0);
        chk("t3_8_cnt", err_cnt, 8);
`ifdef LFSR_CHK_RELOCK_EN
        tick(1'b0, 1'b0);
        chk("t3_auto_exit", lost, 0);
        chk("t3_cnt_kept", err_cnt, 8);
`else
        send_n(10);
        chk("t3_sticky", lost, 1);
        chk("t3_lost_err", err, 0);
        chk("t3_lost_cnt", err_cnt, 8);
        clr_cnt = 1'b1;
        tick(1'b0, 1'b0);
        clr_cnt = 1'b0;
        chk("t3_clr_exit", lost, 0);
        chk("t3_clr_cnt", err_cnt, 0);
`endif
        send_n(47);
        chk("t3_not_yet", locked, 0);
        send(1'b0);
        chk("t3_relocked", locked, 1);

        // 4: all-zero and random input never lock
        do_reset();
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b0);
        chk("t4_zero_locked", locked, 0);
        for (int i = 0; i < 500; i++) tick(1'b1, 1'($urandom_range(1)));
        chk("t4_rand_locked", locked, 0);
        chk("t4_rand_cnt", err_cnt, 0);

        // 5: 50% valid duty on a clean stream
        do_reset();
        for (int i = 0; i < 47; i++) begin
            send(1'b0);
            tick(1'b0, 1'($urandom_range(1)));
        end
        chk("t5_not_yet", locked, 0);
        send(1'b0);
        chk("t5_locked", locked, 1);
        for (int i = 0; i < 100; i++) begin
            send(1'b0);
            tick(1'b0, 1'($urandom_range(1)));
        end
        chk("t5_cnt0", err_cnt, 0);
        chk("t5_still_locked", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
